// File: rtl/csa_insert_sched.sv
// rtl/csa_insert_sched.sv - two-source EMM packet buffer and slot insertion scheduler
// Optional macro CSA_SCHED_PRIO_EN: head wins ties instead of round-robin.

module csa_insert_sched #(
   parameter int PKT_LEN = 188
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] emm_din,
   input  logic       emm_din_en,
   input  logic [8:0] head_din,
   input  logic       head_din_en,
   input  logic       slot_req,
   output logic [8:0] ins_dout,
   output logic       ins_dout_en,
   output logic       ins_busy,
   output logic       emm_drop,
   output logic       head_drop
);

   typedef enum logic {W_IDLE, W_FILL} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_LAST} rstate_t;

   localparam logic [7:0] LAST_ADDR = 8'(PKT_LEN - 1);

   // channel 0 = EMM, channel 1 = head
   logic [8:0] din     [2];
   logic       din_en  [2];
   logic [7:0] mem_q   [2][PKT_LEN];
   wstate_t    wst_q   [2];
   logic [7:0] wcnt_q  [2];
   logic       full_q  [2];
   logic       drop_q  [2];
   logic       wr_en   [2];
   logic [7:0] wr_addr [2];

   rstate_t    rstate_q;
   logic       rch_q;
   logic [7:0] raddr_q;
   logic [8:0] dout_q;
   logic       dout_en_q;
   logic       busy_q;
   logic       gnt_d;

   assign din[0]    = emm_din;
   assign din[1]    = head_din;
   assign din_en[0] = emm_din_en;
   assign din_en[1] = head_din_en;

`ifdef CSA_SCHED_PRIO_EN
   assign gnt_d = full_q[1];
`else
   logic ptr_q;
   assign gnt_d = (full_q[0] && full_q[1]) ? ~ptr_q : full_q[1];
`endif

   // A full buffer never accepts writes, so reads and fills cannot collide.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         wr_en[c]   = din_en[c] && (din[c][8] ? !full_q[c] : (wst_q[c] == W_FILL));
         wr_addr[c] = din[c][8] ? 8'd0 : wcnt_q[c];
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (wr_en[c]) mem_q[c][wr_addr[c]] <= din[c][7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            wst_q[c]  <= W_IDLE;
            wcnt_q[c] <= 8'd0;
            full_q[c] <= 1'b0;
            drop_q[c] <= 1'b0;
         end
         rstate_q  <= R_IDLE;
         rch_q     <= 1'b0;
         raddr_q   <= 8'd0;
         dout_q    <= 9'd0;
         dout_en_q <= 1'b0;
         busy_q    <= 1'b0;
`ifndef CSA_SCHED_PRIO_EN
         ptr_q     <= 1'b1;
`endif
      end else begin
         for (int c = 0; c < 2; c++) begin
            drop_q[c] <= 1'b0;
            case (wst_q[c])
               W_IDLE: begin
                  if (din_en[c] && din[c][8]) begin
                     if (full_q[c]) begin
                        drop_q[c] <= 1'b1;
                     end else begin
                        wst_q[c]  <= W_FILL;
                        wcnt_q[c] <= 8'd1;
                     end
                  end
               end
               W_FILL: begin
                  if (!din_en[c]) begin
                     drop_q[c] <= 1'b1;
                     wst_q[c]  <= W_IDLE;
                  end else if (din[c][8]) begin
                     drop_q[c] <= 1'b1;
                     wcnt_q[c] <= 8'd1;
                  end else begin
                     wcnt_q[c] <= wcnt_q[c] + 8'd1;
                     if (wcnt_q[c] == LAST_ADDR) begin
                        wst_q[c]  <= W_IDLE;
                        full_q[c] <= 1'b1;
                     end
                  end
               end
               default: wst_q[c] <= W_IDLE;
            endcase
         end

         case (rstate_q)
            R_IDLE: begin
               if (slot_req && (full_q[0] || full_q[1])) begin
                  rch_q    <= gnt_d;
                  raddr_q  <= 8'd0;
                  busy_q   <= 1'b1;
                  rstate_q <= R_READ;
`ifndef CSA_SCHED_PRIO_EN
                  ptr_q    <= gnt_d;
`endif
               end
            end
            R_READ: begin
               dout_q    <= {raddr_q == 8'd0, mem_q[rch_q][raddr_q]};
               dout_en_q <= 1'b1;
               raddr_q   <= raddr_q + 8'd1;
               if (raddr_q == LAST_ADDR) rstate_q <= R_LAST;
            end
            R_LAST: begin
               dout_q        <= 9'd0;
               dout_en_q     <= 1'b0;
               busy_q        <= 1'b0;
               full_q[rch_q] <= 1'b0;
               rstate_q      <= R_IDLE;
            end
            default: rstate_q <= R_IDLE;
         endcase
      end
   end

   assign ins_dout    = dout_q;
   assign ins_dout_en = dout_en_q;
   assign ins_busy    = busy_q;
   assign emm_drop    = drop_q[0];
   assign head_drop   = drop_q[1];

endmodule

// File: tb/tb_csa_insert_sched.sv
// tb/tb_csa_insert_sched.sv - scoreboard bench for csa_insert_sched
// Packet-level queue model predicts output bytes, busy window and drop pulses.

module tb_csa_insert_sched;

   localparam int PKT_LEN = 188;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] emm_din, head_din;
   logic       emm_din_en, head_din_en, slot_req;
   logic [8:0] ins_dout;
   logic       ins_dout_en, ins_busy, emm_drop, head_drop;

   csa_insert_sched #(.PKT_LEN(PKT_LEN)) dut (
      .clk(clk), .rst(rst),
      .emm_din(emm_din), .emm_din_en(emm_din_en),
      .head_din(head_din), .head_din_en(head_din_en),
      .slot_req(slot_req),
      .ins_dout(ins_dout), .ins_dout_en(ins_dout_en), .ins_busy(ins_busy),
      .emm_drop(emm_drop), .head_drop(head_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;

   typedef struct { int cyc; logic [8:0] data; } exp_t;
   exp_t       exp_q [$];
   int         drop_q [2][$];
   logic [9:0] src_q [2][$];

   logic [7:0] m_buf [2][$];
   logic [7:0] m_pkt [2][$];
   bit         m_full [2];
   bit         m_coll [2];
   bit         m_ptr;
   bit         rel_pend;
   int         rel_cyc, rel_ch, rd_free;
   int         busy_lo = 1;
   int         busy_hi = 0;

   task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic model_reset(input int k);
      while (exp_q.size() > 0 && exp_q[$].cyc > k) void'(exp_q.pop_back());
      if (busy_hi > k) busy_hi = k;
      for (int c = 0; c < 2; c++) begin
         m_full[c] = 1'b0;
         m_coll[c] = 1'b0;
         m_buf[c].delete();
      end
      m_ptr    = 1'b1;
      rel_pend = 1'b0;
      rd_free  = k + 1;
   endtask

   task automatic model_cycle(input int k, input bit sr, input logic [9:0] w0, input logic [9:0] w1);
      logic [9:0] w [2];
      int   ch;
      exp_t e;
      w[0] = w0;
      w[1] = w1;
      if (rel_pend && k == rel_cyc) begin
         m_full[rel_ch] = 1'b0;
         rel_pend = 1'b0;
      end
      if (sr && k >= rd_free && (m_full[0] || m_full[1])) begin
         if (m_full[0] && m_full[1]) begin
`ifdef CSA_SCHED_PRIO_EN
            ch = 1;
`else
            ch = m_ptr ? 0 : 1;
`endif
         end else begin
            ch = m_full[1] ? 1 : 0;
         end
         m_ptr = (ch == 1);
         for (int i = 0; i < PKT_LEN; i++) begin
            e.cyc  = k + 2 + i;
            e.data = {(i == 0), m_pkt[ch][i]};
            exp_q.push_back(e);
         end
         busy_lo  = k + 1;
         busy_hi  = k + PKT_LEN + 1;
         rd_free  = k + PKT_LEN + 2;
         rel_cyc  = k + PKT_LEN + 2;
         rel_ch   = ch;
         rel_pend = 1'b1;
      end
      for (int c = 0; c < 2; c++) begin
         if (w[c][9] && w[c][8]) begin
            if (m_full[c]) begin
               drop_q[c].push_back(k + 1);
            end else begin
               if (m_coll[c]) drop_q[c].push_back(k + 1);
               m_buf[c].delete();
               m_buf[c].push_back(w[c][7:0]);
               m_coll[c] = 1'b1;
            end
         end else if (w[c][9]) begin
            if (m_coll[c]) begin
               m_buf[c].push_back(w[c][7:0]);
               if (m_buf[c].size() == PKT_LEN) begin
                  m_pkt[c]  = m_buf[c];
                  m_full[c] = 1'b1;
                  m_coll[c] = 1'b0;
               end
            end
         end else if (m_coll[c]) begin
            drop_q[c].push_back(k + 1);
            m_coll[c] = 1'b0;
         end
      end
   endtask

   task automatic tick(input bit sr, input bit r);
      logic [9:0] w [2];
      for (int c = 0; c < 2; c++) begin
         if (src_q[c].size() > 0) w[c] = src_q[c].pop_front();
         else w[c] = 10'd0;
      end
      rst         = r;
      slot_req    = sr;
      emm_din_en  = w[0][9];
      emm_din     = w[0][8:0];
      head_din_en = w[1][9];
      head_din    = w[1][8:0];
      if (r) model_reset(cyc);
      else model_cycle(cyc, sr, w[0], w[1]);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick(1'b0, 1'b0);
   endtask

   task automatic push_pkt(input int c, input int len, input bit pat);
      logic [7:0] b;
      for (int i = 0; i < len; i++) begin
         if (pat) b = (i == 0) ? 8'h47 : 8'(i);
         else b = 8'($urandom);
         src_q[c].push_back({1'b1, (i == 0), b});
      end
   endtask

   task automatic push_gap(input int c, input int n);
      repeat (n) src_q[c].push_back(10'd0);
   endtask

   task automatic push_rand(input int c);
      int r;
      int len;
      r = int'($urandom % 8);
      if (r < 5) len = PKT_LEN;
      else if (r == 5) len = PKT_LEN + 1 + int'($urandom % 4);
      else len = 1 + int'($urandom % (PKT_LEN - 1));
      if ($urandom % 4 == 0) src_q[c].push_back({2'b10, 8'($urandom)});
      push_gap(c, int'($urandom % 4));
      push_pkt(c, len, 1'b0);
   endtask

   task automatic drain();
      repeat (2) begin
         tick(1'b1, 1'b0);
         run(PKT_LEN + 3);
      end
   endtask

   always @(negedge clk) begin : monitor
      bit   eb;
      logic act;
      if (mon_en) begin
         checks++;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            if (ins_dout_en !== 1'b1 || ins_dout !== exp_q[0].data) begin
               failures++;
               $display("FAIL out_byte cyc=%0d got en=%b data=%h exp en=1 data=%h",
                        cyc, ins_dout_en, ins_dout, exp_q[0].data);
            end
            void'(exp_q.pop_front());
         end else if (ins_dout_en !== 1'b0) begin
            failures++;
            $display("FAIL out_idle cyc=%0d got en=%b data=%h exp en=0", cyc, ins_dout_en, ins_dout);
         end
         checks++;
         eb = (cyc >= busy_lo && cyc <= busy_hi);
         if (ins_busy !== eb) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, ins_busy, eb);
         end
         for (int c = 0; c < 2; c++) begin
            checks++;
            eb = (drop_q[c].size() > 0 && drop_q[c][0] == cyc);
            if (eb) void'(drop_q[c].pop_front());
            act = (c == 0) ? emm_drop : head_drop;
            if (act !== eb) begin
               failures++;
               $display("FAIL drop%0d cyc=%0d got=%b exp=%b", c, cyc, act, eb);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; slot_req = 1'b0;
      emm_din = 9'd0; emm_din_en = 1'b0; head_din = 9'd0; head_din_en = 1'b0;
      @(posedge clk);
      #1;
      repeat (3) tick(1'b0, 1'b1);
      mon_en = 1'b1;
      chk("rst_dout", ins_dout, 9'd0);
      chk("rst_dout_en", {8'd0, ins_dout_en}, 9'd0);
      chk("rst_busy", {8'd0, ins_busy}, 9'd0);
      chk("rst_emm_drop", {8'd0, emm_drop}, 9'd0);
      chk("rst_head_drop", {8'd0, head_drop}, 9'd0);

      // single EMM packet 0x47, 0x01..0xBB
      push_pkt(0, PKT_LEN, 1'b1);
      run(PKT_LEN + 2);
      tick(1'b1, 1'b0);
      run(PKT_LEN + 10);

      // both full, three grants with refills between them
      push_pkt(0, PKT_LEN, 1'b0);
      push_pkt(1, PKT_LEN, 1'b0);
      run(PKT_LEN + 2);
      tick(1'b1, 1'b0);
      run(199);
      tick(1'b1, 1'b0);
      run(PKT_LEN + 3);
      push_pkt(1, PKT_LEN, 1'b0);
      push_pkt(0, PKT_LEN, 1'b0);
      run(PKT_LEN + 5);
      tick(1'b1, 1'b0);
      run(PKT_LEN + 10);
      drain();

      // short EMM packet then slot_req
      push_pkt(0, 100, 1'b0);
      push_gap(0, 5);
      run(110);
      tick(1'b1, 1'b0);
      run(10);

      // second head SOP while head buffer is full
      push_pkt(1, PKT_LEN, 1'b0);
      push_pkt(1, PKT_LEN, 1'b0);
      run(2 * PKT_LEN + 5);
      tick(1'b1, 1'b0);
      run(PKT_LEN + 5);

      // slot_req with both empty, then slot_req during a read
      tick(1'b1, 1'b0);
      run(5);
      push_pkt(0, PKT_LEN, 1'b0);
      push_pkt(1, PKT_LEN, 1'b0);
      run(PKT_LEN + 2);
      tick(1'b1, 1'b0);
      run(20);
      tick(1'b1, 1'b0);
      run(PKT_LEN + 5);
      drain();

      // reset at byte 50 of a read
      push_pkt(0, PKT_LEN, 1'b0);
      run(PKT_LEN + 2);
      tick(1'b1, 1'b0);
      run(50);
      tick(1'b0, 1'b1);
      run(3);
      tick(1'b1, 1'b0);
      run(10);

      repeat (20000) begin
         for (int c = 0; c < 2; c++) begin
            if (src_q[c].size() == 0 && $urandom % 16 == 0) push_rand(c);
         end
         tick($urandom % 64 == 0, $urandom % 5000 == 0);
      end
      src_q[0].delete();
      src_q[1].delete();
      run(PKT_LEN + 10);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_bytes got=%0d exp=0", exp_q.size());
      end
      checks++;
      if (drop_q[0].size() + drop_q[1].size() != 0) begin
         failures++;
         $display("FAIL pending_drops got=%0d exp=0", drop_q[0].size() + drop_q[1].size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
